// File: rtl/led_pkg.sv
// Shared fade-state type and peak-duty helper for the LED fade driver.
package led_pkg;

    typedef enum logic [1:0] {
        FADE_OFF,
        FADE_RISE,
        FADE_ON,
        FADE_FALL
    } fade_state_e;

    // Peak duty is a quarter-step fraction of the full PWM scale.
    function automatic int unsigned max_duty(input logic [1:0] brightness,
                                             input int unsigned pwm_bits);
        int unsigned full;
        full = (32'd1 << pwm_bits) - 32'd1;
        return ((32'(brightness) + 32'd1) * full) / 32'd4;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: steps its duty toward the requested level once per fade tick
// and turns the duty into a registered PWM output.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                req,
    input  logic [PWM_BITS-1:0] peak,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                pwm_en,
    output logic                led,
    output logic                ramping
);

    localparam int unsigned           W      = PWM_BITS + 1;
    localparam logic [W-1:0]          STEP_W = W'(STEP);
    localparam logic [PWM_BITS-1:0]   STEP_N = PWM_BITS'(STEP);

    fade_state_e         state, state_next;
    logic [PWM_BITS-1:0] duty, duty_next, target;
    logic [W-1:0]        gap;

    always_comb begin
        target     = req ? peak : '0;
        gap        = '0;
        duty_next  = duty;
        state_next = state;
        if (tick) begin
            // Distance is taken one bit wider so a large step clamps to the target instead of wrapping.
            if (duty < target) begin
                gap       = {1'b0, target} - {1'b0, duty};
                duty_next = (gap > STEP_W) ? duty + STEP_N : target;
            end else if (duty > target) begin
                gap       = {1'b0, duty} - {1'b0, target};
                duty_next = (gap > STEP_W) ? duty - STEP_N : target;
            end

            if (duty_next < target) begin
                state_next = FADE_RISE;
            end else if (duty_next > target) begin
                state_next = FADE_FALL;
            end else if (target == '0) begin
                state_next = FADE_OFF;
            end else begin
                state_next = FADE_ON;
            end
        end
        ramping = (state_next == FADE_RISE) || (state_next == FADE_FALL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FADE_OFF;
            duty  <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_next;
            duty  <= duty_next;
            led   <= pwm_en & (duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// Fades the blink pattern onto the board LEDs: shared fade-tick prescaler and
// PWM counter, one fade channel per LED, and an aggregated busy flag.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned RAMP_DIV = 390_625,
    parameter int unsigned STEP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_LED-1:0] pattern_i,
    input  logic [1:0]       brightness_i,
    input  logic             pwm_en_i,
    output logic [N_LED-1:0] led_o,
    output logic             busy_o
);

    localparam int unsigned         DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);
    // PWM period is 2^PWM_BITS-1 so the top duty value is a constant-on output.
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    logic [DIV_W-1:0]    presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] peak;
    logic [N_LED-1:0]    ramping;

    assign tick = (presc == DIV_LAST);
    assign peak = PWM_BITS'(max_duty(brightness_i, PWM_BITS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
            busy_o  <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + DIV_W'(1);
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
            busy_o  <= |ramping;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .req     (pattern_i[i]),
            .peak    (peak),
            .pwm_cnt (pwm_cnt),
            .pwm_en  (pwm_en_i),
            .led     (led_o[i]),
            .ramping (ramping[i])
        );
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with a small cycle-level reference model.
module tb_led_fade_driver;

    localparam int NL  = 4;
    localparam int PB  = 4;
    localparam int RD  = 4;
    localparam int PER = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] pattern = '0;
    logic [1:0]    brightness = '0;
    logic          pwm_en = 1'b1;
    logic [NL-1:0] led_o;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles since reset release, duty per LED, expected outputs.
    int            m_k;
    int            m_duty[NL];
    logic [NL-1:0] m_led;
    logic          m_busy;

    always #5 clk = ~clk;

    led_fade_driver #(
        .N_LED    (NL),
        .PWM_BITS (PB),
        .RAMP_DIV (RD),
        .STEP     (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pattern_i    (pattern),
        .brightness_i (brightness),
        .pwm_en_i     (pwm_en),
        .led_o        (led_o),
        .busy_o       (busy_o)
    );

    function automatic int peak_of(input logic [1:0] b);
        return ((int'(b) + 1) * PER) / 4;
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic cycle();
        int   tgt;
        logic any;
        @(posedge clk);
        if (!rst_n) begin
            m_k    = 0;
            m_led  = '0;
            m_busy = 1'b0;
            for (int i = 0; i < NL; i++) m_duty[i] = 0;
        end else begin
            for (int i = 0; i < NL; i++) m_led[i] = pwm_en && (m_duty[i] > (m_k % PER));
            if ((m_k % RD) == RD - 1) begin
                any = 1'b0;
                for (int i = 0; i < NL; i++) begin
                    tgt = pattern[i] ? peak_of(brightness) : 0;
                    if (m_duty[i] < tgt)      m_duty[i] = (m_duty[i] + 1 > tgt) ? tgt : m_duty[i] + 1;
                    else if (m_duty[i] > tgt) m_duty[i] = (m_duty[i] - 1 < tgt) ? tgt : m_duty[i] - 1;
                    if (m_duty[i] != tgt) any = 1'b1;
                end
                m_busy = any;
            end
            m_k++;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        pattern    = '0;
        brightness = '0;
        pwm_en     = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (led_o !== '0) begin
            errors++;
            $display("FAIL reset_led got=%b want=0000", led_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b want=0", busy_o);
        end
        // Mid-ramp reset at duty 6 (six ticks of a full-brightness rise).
        pattern    = 4'b0001;
        brightness = 2'd3;
        repeat (24) cycle();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midramp_busy got=%b want=1", busy_o);
        end
        rst_n = 1'b0;
        cycle();
        checks++;
        if (led_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midramp_reset led=%b busy=%b want led=0000 busy=0", led_o, busy_o);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            checks++;
            if (busy_o !== (c >= 4)) begin
                errors++;
                $display("FAIL rerampbusy c=%0d got=%b want=%b", c, busy_o, (c >= 4));
            end
            checks++;
            if (led_o !== m_led) begin
                errors++;
                $display("FAIL reramp_led c=%0d got=%b want=%b", c, led_o, m_led);
            end
        end
    endtask

    task automatic test_full_ramp();
        apply_reset();
        pattern    = 4'b0001;
        brightness = 2'd3;
        for (int c = 1; c <= 90; c++) begin
            cycle();
            checks++;
            if (busy_o !== (c >= 4 && c < 60)) begin
                errors++;
                $display("FAIL ramp_busy c=%0d got=%b want=%b", c, busy_o, (c >= 4 && c < 60));
            end
            checks++;
            if (led_o[3:1] !== 3'b000) begin
                errors++;
                $display("FAIL ramp_idle_leds c=%0d got=%b want=000", c, led_o[3:1]);
            end
            if (c >= 61) begin
                checks++;
                if (led_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL ramp_full_on c=%0d got=%b want=1", c, led_o[0]);
                end
            end else begin
                checks++;
                if (led_o !== m_led) begin
                    errors++;
                    $display("FAIL ramp_led c=%0d got=%b want=%b", c, led_o, m_led);
                end
            end
        end
    endtask

    task automatic test_duty_accuracy();
        int high;
        apply_reset();
        pattern    = 4'b0001;
        brightness = 2'd1;
        repeat (45) cycle();
        for (int p = 0; p < 3; p++) begin
            high = 0;
            repeat (PER) begin
                cycle();
                if (led_o[0] === 1'b1) high++;
            end
            checks++;
            if (high != 7) begin
                errors++;
                $display("FAIL duty_accuracy period=%0d high=%0d want=7", p, high);
            end
        end
    endtask

    task automatic test_reversal();
        apply_reset();
        pattern    = 4'b0001;
        brightness = 2'd3;
        repeat (20) cycle();
        pattern = 4'b0000;
        for (int c = 21; c <= 50; c++) begin
            cycle();
            checks++;
            if (busy_o !== (c < 40)) begin
                errors++;
                $display("FAIL reversal_busy c=%0d got=%b want=%b", c, busy_o, (c < 40));
            end
            checks++;
            if (led_o !== m_led) begin
                errors++;
                $display("FAIL reversal_led c=%0d got=%b want=%b", c, led_o, m_led);
            end
        end
    endtask

    task automatic test_blanking();
        apply_reset();
        pattern    = 4'b0101;
        brightness = 2'd3;
        repeat (20) cycle();
        pwm_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (led_o !== '0) begin
                errors++;
                $display("FAIL blank_led c=%0d got=%b want=0000", c, led_o);
            end
            checks++;
            if (busy_o !== m_busy) begin
                errors++;
                $display("FAIL blank_busy c=%0d got=%b want=%b", c, busy_o, m_busy);
            end
        end
        pwm_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            checks++;
            if (led_o !== m_led || busy_o !== m_busy) begin
                errors++;
                $display("FAIL unblank c=%0d led=%b busy=%b want led=%b busy=%b",
                         c, led_o, busy_o, m_led, m_busy);
            end
        end
    endtask

    task automatic test_retarget();
        int high;
        apply_reset();
        pattern    = 4'b0001;
        brightness = 2'd3;
        repeat (64) cycle();
        brightness = 2'd0;
        for (int c = 65; c <= 130; c++) begin
            cycle();
            checks++;
            if (busy_o !== (c >= 68 && c < 112)) begin
                errors++;
                $display("FAIL retarget_busy c=%0d got=%b want=%b", c, busy_o, (c >= 68 && c < 112));
            end
            checks++;
            if (led_o !== m_led) begin
                errors++;
                $display("FAIL retarget_led c=%0d got=%b want=%b", c, led_o, m_led);
            end
        end
        high = 0;
        repeat (PER) begin
            cycle();
            if (led_o[0] === 1'b1) high++;
        end
        checks++;
        if (high != 3) begin
            errors++;
            $display("FAIL retarget_duty high=%0d want=3", high);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) pattern = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) brightness = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pwm_en = ~pwm_en;
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            checks++;
            if (led_o !== m_led) begin
                errors++;
                $display("FAIL random_led c=%0d got=%b want=%b", c, led_o, m_led);
            end
            checks++;
            if (busy_o !== m_busy) begin
                errors++;
                $display("FAIL random_busy c=%0d got=%b want=%b", c, busy_o, m_busy);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_ramp();
        test_duty_accuracy();
        test_reversal();
        test_blanking();
        test_retarget();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
